// File: rtl/input_skew_feeder_if.sv
// Handshake and operand bus between the upstream pair source and input_skew_feeder.
// The optional stall_cnt statistic (FEEDER_STATS_EN) is a plain port on the feeder, not part of this bus.
interface input_skew_feeder_if;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        start;
    logic [7:0]  k_len;
    logic        busy;
    logic [31:0] row0_data;
    logic        row0_valid;
    logic [31:0] row1_data;
    logic        row1_valid;
    logic        tile_done;

    modport master (
        output in_valid, in_data, start, k_len,
        input  in_ready, busy, row0_data, row0_valid, row1_data, row1_valid, tile_done
    );

    modport slave (
        input  in_valid, in_data, start, k_len,
        output in_ready, busy, row0_data, row0_valid, row1_data, row1_valid, tile_done
    );
endinterface

// File: rtl/input_skew_feeder.sv
// Buffers 64-bit element pairs and feeds them to a systolic edge, row 1 skewed one cycle behind row 0.
// Define FEEDER_STATS_EN to add the saturating stall_cnt output.
module input_skew_feeder #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    input_skew_feeder_if.slave bus
`ifdef FEEDER_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StFeed, StDrain} state_e;

    logic [63:0]     mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push, pop, fifo_nonempty;
    logic [63:0]     pop_data;

    state_e      state_q;
    logic [7:0]  remaining_q;
    logic [31:0] row0_data_q, row1_data_q, lo_dly_q;
    logic        row0_valid_q, row1_valid_q, lo_vld_q, tile_done_q;

    assign fifo_nonempty = (count_q != '0);
    assign bus.in_ready  = (count_q < CntW'(FIFO_DEPTH)) && !rst;
    assign push          = bus.in_valid && bus.in_ready;
    // Pop only from registered occupancy, so a pair pushed this edge is not visible until the next.
    assign pop           = (state_q == StFeed) && fifo_nonempty;
    assign pop_data      = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            remaining_q  <= '0;
            row0_data_q  <= '0;
            row0_valid_q <= 1'b0;
            row1_data_q  <= '0;
            row1_valid_q <= 1'b0;
            lo_dly_q     <= '0;
            lo_vld_q     <= 1'b0;
            tile_done_q  <= 1'b0;
        end else begin
            // Row 1 always replays the low half held back from the previous cycle.
            row1_data_q  <= lo_vld_q ? lo_dly_q : '0;
            row1_valid_q <= lo_vld_q;
            tile_done_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    row0_data_q  <= '0;
                    row0_valid_q <= 1'b0;
                    lo_vld_q     <= 1'b0;
                    if (bus.start) begin
                        if (bus.k_len != 8'd0) begin
                            remaining_q <= bus.k_len;
                            state_q     <= StFeed;
                        end else begin
                            tile_done_q <= 1'b1;
                        end
                    end
                end
                StFeed: begin
                    if (pop) begin
                        row0_data_q  <= pop_data[63:32];
                        row0_valid_q <= 1'b1;
                        lo_dly_q     <= pop_data[31:0];
                        lo_vld_q     <= 1'b1;
                        remaining_q  <= remaining_q - 8'd1;
                        if (remaining_q == 8'd1) state_q <= StDrain;
                    end else begin
                        row0_data_q  <= '0;
                        row0_valid_q <= 1'b0;
                        lo_vld_q     <= 1'b0;
                    end
                end
                StDrain: begin
                    row0_data_q  <= '0;
                    row0_valid_q <= 1'b0;
                    lo_vld_q     <= 1'b0;
                    tile_done_q  <= 1'b1;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy       = (state_q != StIdle);
    assign bus.row0_data  = row0_data_q;
    assign bus.row0_valid = row0_valid_q;
    assign bus.row1_data  = row1_data_q;
    assign bus.row1_valid = row1_valid_q;
    assign bus.tile_done  = tile_done_q;

`ifdef FEEDER_STATS_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || (state_q == StIdle && bus.start)) begin
            stall_cnt_q <= '0;
        end else if (state_q == StFeed && !fifo_nonempty && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_input_skew_feeder.sv
// Self-checking bench for input_skew_feeder: directed scenarios then random traffic,
// every cycle compared against a queue-based model of the feeder's behaviour.
module tb_input_skew_feeder;
    localparam int unsigned Depth = 4;

    logic clk;
    logic rst;
    input_skew_feeder_if ifc ();
`ifdef FEEDER_STATS_EN
    logic [15:0] stall_cnt;
`endif

    input_skew_feeder #(.FIFO_DEPTH(Depth)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
`ifdef FEEDER_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model: FIFO contents as a queue; row 1 is the partner of what row 0 showed last cycle.
    logic [63:0] q[$];
    int          m_mode  = 0;  // 0 idle, 1 feeding, 2 final row-1 cycle
    int          m_rem   = 0;
    logic [31:0] m_row0  = '0;
    logic [31:0] m_lo    = '0;
    logic        m_v0    = 1'b0;
    logic [31:0] m_row1  = '0;
    logic        m_v1    = 1'b0;
    logic        m_done  = 1'b0;
    int          m_stall = 0;

    int unsigned e0[5] = '{1, 3, 5, 0, 0};
    int unsigned e1[5] = '{0, 2, 4, 6, 0};
    int unsigned ed[5] = '{0, 0, 0, 1, 0};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [63:0] pr;
        logic [31:0] n0, nlo;
        logic        nv0, nd, push;
        if (rst) begin
            q.delete();
            m_mode = 0; m_rem = 0; m_row0 = '0; m_lo = '0; m_v0 = 1'b0;
            m_row1 = '0; m_v1 = 1'b0; m_done = 1'b0; m_stall = 0;
            return;
        end
        push   = ifc.in_valid && (q.size() < Depth);
        m_row1 = m_v0 ? m_lo : 32'd0;
        m_v1   = m_v0;
        n0 = '0; nlo = '0; nv0 = 1'b0; nd = 1'b0;
        case (m_mode)
            0: if (ifc.start) begin
                m_stall = 0;
                if (ifc.k_len == 8'd0) nd = 1'b1;
                else begin
                    m_rem  = int'(ifc.k_len);
                    m_mode = 1;
                end
            end
            1: if (q.size() > 0) begin
                pr  = q.pop_front();
                n0  = pr[63:32];
                nlo = pr[31:0];
                nv0 = 1'b1;
                m_rem--;
                if (m_rem == 0) m_mode = 2;
            end else if (m_stall < 65535) begin
                m_stall++;
            end
            default: begin
                nd     = 1'b1;
                m_mode = 0;
            end
        endcase
        m_row0 = n0; m_lo = nlo; m_v0 = nv0; m_done = nd;
        if (push) q.push_back(ifc.in_data);
    endtask

    task automatic compare();
        check("in_ready", {63'd0, ifc.in_ready}, {63'd0, (q.size() < Depth) && !rst});
        check("busy", {63'd0, ifc.busy}, {63'd0, m_mode != 0});
        check("row0_valid", {63'd0, ifc.row0_valid}, {63'd0, m_v0});
        check("row0_data", {32'd0, ifc.row0_data}, {32'd0, m_row0});
        check("row1_valid", {63'd0, ifc.row1_valid}, {63'd0, m_v1});
        check("row1_data", {32'd0, ifc.row1_data}, {32'd0, m_row1});
        check("tile_done", {63'd0, ifc.tile_done}, {63'd0, m_done});
`ifdef FEEDER_STATS_EN
        check("stall_cnt", {48'd0, stall_cnt}, 64'(m_stall));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic s, input logic [7:0] k);
        ifc.in_valid = v;
        ifc.in_data  = d;
        ifc.start    = s;
        ifc.k_len    = k;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 64'd0, 1'b0, 8'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("ready_after_rst", {63'd0, ifc.in_ready}, 64'd1);

        // Preloaded three-pair tile
        drive(1'b1, {32'd1, 32'd2}, 1'b0, 8'd0); step();
        drive(1'b1, {32'd3, 32'd4}, 1'b0, 8'd0); step();
        drive(1'b1, {32'd5, 32'd6}, 1'b0, 8'd0); step();
        drive(1'b0, 64'd0, 1'b1, 8'd3); step();
        drive(1'b0, 64'd0, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("pre_row0", {32'd0, ifc.row0_data}, 64'(e0[i]));
            check("pre_row1", {32'd0, ifc.row1_data}, 64'(e1[i]));
            check("pre_done", {63'd0, ifc.tile_done}, 64'(ed[i]));
        end

        // Start on an empty FIFO, data arrives late
        drive(1'b0, 64'd0, 1'b1, 8'd2); step();
        drive(1'b0, 64'd0, 1'b0, 8'd0); step(); step();
        drive(1'b1, {32'hA, 32'hB}, 1'b0, 8'd0); step();
        drive(1'b1, {32'hC, 32'hD}, 1'b0, 8'd0); step();
        drive(1'b0, 64'd0, 1'b0, 8'd0);
`ifdef FEEDER_STATS_EN
        check("stall_three", {48'd0, stall_cnt}, 64'd3);
`endif
        for (int i = 0; i < 4; i++) step();

        // Overfill while idle, then drain through a five-pair tile
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, {32'(100 + i), 32'(200 + i)}, 1'b0, 8'd0);
            step();
            if (i == 3) check("full_ready", {63'd0, ifc.in_ready}, 64'd0);
        end
        drive(1'b1, {32'd104, 32'd204}, 1'b1, 8'd5); step();
        drive(1'b1, {32'd104, 32'd204}, 1'b0, 8'd0); step(); step();
        drive(1'b0, 64'd0, 1'b0, 8'd0);
        for (int i = 0; i < 8; i++) step();

        // Zero-length tile
        drive(1'b0, 64'd0, 1'b1, 8'd0); step();
        check("k0_done", {63'd0, ifc.tile_done}, 64'd1);
        check("k0_busy", {63'd0, ifc.busy}, 64'd0);
        drive(1'b0, 64'd0, 1'b0, 8'd0); step();
        check("k0_done_end", {63'd0, ifc.tile_done}, 64'd0);

        // Reset in the second feed cycle
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, {32'(300 + i), 32'(400 + i)}, 1'b0, 8'd0);
            step();
        end
        drive(1'b0, 64'd0, 1'b1, 8'd4); step();
        drive(1'b0, 64'd0, 1'b0, 8'd0); step();
        rst = 1'b1; step(); step();
        rst = 1'b0;
        drive(1'b1, {32'h55, 32'h66}, 1'b0, 8'd0); step();
        drive(1'b1, {32'h77, 32'h88}, 1'b0, 8'd0); step();
        drive(1'b0, 64'd0, 1'b1, 8'd2); step();
        drive(1'b0, 64'd0, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) step();

        // Steady push and pop at occupancy two across pointer wrap
        drive(1'b1, {32'd500, 32'd600}, 1'b0, 8'd0); step();
        drive(1'b1, {32'd501, 32'd601}, 1'b0, 8'd0); step();
        drive(1'b0, 64'd0, 1'b1, 8'd12); step();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, {32'(502 + i), 32'(602 + i)}, 1'b0, 8'd0);
            step();
        end
        drive(1'b0, 64'd0, 1'b0, 8'd0);
        for (int i = 0; i < 6; i++) step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive(($urandom_range(0, 3) != 0), {$urandom, $urandom},
                  ($urandom_range(0, 7) == 0), 8'($urandom_range(0, 6)));
            step();
        end
        rst = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 8'd0);
        for (int i = 0; i < 10; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
